dcache_controller: RTL

- Direct-mapped, write-back, write-allocate data-cache controller between the 8-bit CPU load/store path and the 32-bit-block data memory.
- Holds tag/valid/dirty/data arrays and the miss FSM.
- Stalls the CPU through BUSYWAIT, which gates PC update and register write-back.
- Sequences memory write-back and refill through a request/busywait handshake.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_array.sv | 58 +++++
 rtl/dcache_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared encodings and field widths for the direct-mapped data cache.
// Byte address = {tag, index, offset}; memory moves whole 32-bit blocks.
package dcache_pkg;

  localparam int ADDR_W     = 8;
  localparam int OFFSET_W   = 2;
  localparam int BYTE_W     = 8;
  localparam int BLOCK_W    = 32;
  localparam int MEM_ADDR_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache.
// Synchronous write ports and combinational read of the selected line.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic                i_wr_en,
  input  logic [BYTE_W-1:0]   i_wdata,
  input  logic                i_fill_en,
  input  logic [TAG_W-1:0]    i_fill_tag,
  input  logic [BLOCK_W-1:0]  i_fill_block,
  output logic                o_valid,
  output logic                o_dirty,
  output logic [TAG_W-1:0]    o_tag,
  output logic [BLOCK_W-1:0]  o_block
);

  localparam int NUM_BLOCKS = 2**INDEX_W;

  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  // Tags and data survive reset; only the valid bits decide whether they count.
  always_ff @(posedge CLK) begin
    if (i_fill_en) begin
      r_tag[i_index]  <= i_fill_tag;
      r_data[i_index] <= i_fill_block;
    end else if (i_wr_en) begin
      r_data[i_index][{i_offset, 3'b000} +: BYTE_W] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_block = r_data[i_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hit logic and the miss FSM (write-back, refill, update) live here.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic                     WRITE,
  input  logic [ADDR_W-1:0]        ADDRESS,
  input  logic [BYTE_W-1:0]        WRITEDATA,
  output logic [BYTE_W-1:0]        READDATA,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic                     MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]       MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]       MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  state_t r_state, w_next;

  logic [TAG_W-1:0]    r_miss_tag;
  logic [INDEX_W-1:0]  r_miss_index;
  logic [BLOCK_W-1:0]  r_fill;
  logic [BYTE_W-1:0]   r_readdata;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic [INDEX_W-1:0]  w_arr_index;
  logic                w_valid, w_dirty, w_hit, w_idle_hit, w_req;
  logic                w_rd_hit, w_wr_hit, w_fill_en;
  logic [TAG_W-1:0]    w_stored_tag;
  logic [BLOCK_W-1:0]  w_block;
  logic [BYTE_W-1:0]   w_byte;

  assign w_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign w_index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign w_offset = ADDRESS[OFFSET_W-1:0];

  // During a miss the line is addressed by the latched request, so a dropped
  // or changed CPU address cannot redirect the refill.
  assign w_arr_index = (r_state == IDLE) ? w_index : r_miss_index;

  assign w_req      = READ | WRITE;
  assign w_hit      = w_valid && (w_stored_tag == w_tag);
  assign w_idle_hit = (r_state == IDLE) && w_hit;
  assign w_byte     = w_block[{w_offset, 3'b000} +: BYTE_W];
  assign w_rd_hit   = READ && w_idle_hit && !RESET;
  assign w_wr_hit   = WRITE && w_idle_hit && !RESET;
  assign w_fill_en  = (r_state == UPDATE) && !RESET;

  assign BUSYWAIT = w_req && !w_idle_hit;
  assign READDATA = (READ && w_idle_hit) ? w_byte : r_readdata;

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_index      (w_arr_index),
    .i_offset     (w_offset),
    .i_wr_en      (w_wr_hit),
    .i_wdata      (WRITEDATA),
    .i_fill_en    (w_fill_en),
    .i_fill_tag   (r_miss_tag),
    .i_fill_block (r_fill),
    .o_valid      (w_valid),
    .o_dirty      (w_dirty),
    .o_tag        (w_stored_tag),
    .o_block      (w_block)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (r_state == IDLE && w_req && !w_hit) begin
      r_miss_tag   <= w_tag;
      r_miss_index <= w_index;
    end
    if (r_state == FETCH && !MEM_BUSYWAIT) r_fill <= MEM_READDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET)         r_readdata <= '0;
    else if (w_rd_hit) r_readdata <= w_byte;
  end

  always_comb begin
    w_next        = r_state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) w_next = (w_valid && w_dirty) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {w_stored_tag, r_miss_index};
        MEM_WRITEDATA = w_block;
        if (!MEM_BUSYWAIT) w_next = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {r_miss_tag, r_miss_index};
        if (!MEM_BUSYWAIT) w_next = UPDATE;
      end
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

endmodule
